// File: rtl/cu_seq_if.sv
// cu_seq_if: sequencing inputs from the control buffer/IR and the sequencer's registered outputs
interface cu_seq_if #(
   parameter int ADDR_W = 8,
   parameter int OP_W   = 8
);
   logic              ctrl_cpu_start;
   logic [1:0]        next_addr;
   logic              ctrl_global_halt;
   logic [OP_W-1:0]   ir_opcode;
   logic              cond_flag;
   logic [ADDR_W-1:0] car;
   logic              running;
   logic              halted;
   logic              illegal_op;
   logic [15:0]       ustep_count;
   modport master (
      output ctrl_cpu_start, next_addr, ctrl_global_halt, ir_opcode, cond_flag,
      input  car, running, halted, illegal_op, ustep_count
   );
   modport slave (
      input  ctrl_cpu_start, next_addr, ctrl_global_halt, ir_opcode, cond_flag,
      output car, running, halted, illegal_op, ustep_count
   );
endinterface

// File: rtl/cu_micro_sequencer.sv
// cu_micro_sequencer: control address register with next-address selection, run/halt FSM and step counter
module cu_micro_sequencer #(
   parameter int              ADDR_W     = 8,
   parameter int              OP_W       = 8,
   parameter logic [ADDR_W-1:0] FETCH_ADDR = 8'h00,
   parameter logic [ADDR_W-1:0] MAP_BASE   = 8'h10,
   parameter int              MAP_STRIDE = 8,
   parameter int              MAX_OPCODE = 15
) (
   input logic    clk,
   input logic    rst_n,
   cu_seq_if.slave sq
);
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] car_q, car_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              ill_q, ill_d;
   logic [ADDR_W-1:0] map_addr, next_car;
   logic [15:0]       cnt_inc;
   logic              op_bad;
   assign op_bad   = sq.ir_opcode > OP_W'(MAX_OPCODE);
   assign map_addr = MAP_BASE + ADDR_W'(sq.ir_opcode) * ADDR_W'(MAP_STRIDE);
   assign cnt_inc  = cnt_q + 16'(cnt_q != 16'hFFFF);
   assign next_car = sq.next_addr == 2'b00 ? car_q + ADDR_W'(1) :
                     sq.next_addr == 2'b01 ? (op_bad ? FETCH_ADDR : map_addr) :
                     sq.next_addr == 2'b10 ? FETCH_ADDR :
                     car_q + ADDR_W'(sq.cond_flag ? 2 : 1);
   always_comb begin
      state_d = state_q;
      car_d   = car_q;
      cnt_d   = cnt_q;
      ill_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            car_d = FETCH_ADDR;
            cnt_d = '0;
            if (sq.ctrl_cpu_start) state_d = RUN;
         end
         RUN: begin
            // dropping start wins over a simultaneous halt request
            if (!sq.ctrl_cpu_start) begin
               state_d = IDLE;
               car_d   = FETCH_ADDR;
               cnt_d   = '0;
            end else if (sq.ctrl_global_halt) begin
               state_d = HALTED;
               cnt_d   = cnt_inc;
            end else begin
               car_d = next_car;
               cnt_d = cnt_inc;
               ill_d = sq.next_addr == 2'b01 && op_bad;
            end
         end
         HALTED: begin
            if (!sq.ctrl_cpu_start) begin
               state_d = IDLE;
               car_d   = FETCH_ADDR;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         car_q   <= FETCH_ADDR;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         car_q   <= car_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
      end
   end
   assign sq.car         = car_q;
   assign sq.running     = state_q == RUN;
   assign sq.halted      = state_q == HALTED;
   assign sq.illegal_op  = ill_q;
   assign sq.ustep_count = cnt_q;
endmodule

// File: tb/tb_cu_micro_sequencer.sv
// tb_cu_micro_sequencer: directed and randomized checks against an arithmetic reference model
module tb_cu_micro_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   cu_seq_if #(.ADDR_W(8), .OP_W(8)) bus ();
   cu_micro_sequencer dut (.clk(clk), .rst_n(rst_n), .sq(bus));
   always #5 clk = ~clk;
   // reference model: 0=idle 1=run 2=halted
   int m_st, m_car, m_cnt, m_ill;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = 0; m_car = 0; m_cnt = 0; m_ill = 0;
      end else begin
         m_ill = 0;
         if (m_st == 0) begin
            m_car = 0; m_cnt = 0;
            if (bus.ctrl_cpu_start) m_st = 1;
         end else if (!bus.ctrl_cpu_start) begin
            m_st = 0; m_car = 0; m_cnt = 0;
         end else if (m_st == 1) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (bus.ctrl_global_halt) m_st = 2;
            else if (bus.next_addr == 2'd0) m_car = (m_car + 1) % 256;
            else if (bus.next_addr == 2'd1) begin
               if (int'(bus.ir_opcode) > 15) begin m_car = 0; m_ill = 1; end
               else m_car = (16 + int'(bus.ir_opcode) * 8) % 256;
            end
            else if (bus.next_addr == 2'd2) m_car = 0;
            else m_car = (m_car + (bus.cond_flag ? 2 : 1)) % 256;
         end
      end
   end
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask
   task automatic cmp_model();
      chk("car", int'(bus.car), m_car);
      chk("running", int'(bus.running), int'(m_st == 1));
      chk("halted", int'(bus.halted), int'(m_st == 2));
      chk("illegal_op", int'(bus.illegal_op), m_ill);
      chk("ustep_count", int'(bus.ustep_count), m_cnt);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      cmp_model();
   endtask
   task automatic drive(input bit s, input bit h, input logic [1:0] na, input logic [7:0] op, input bit c);
      bus.ctrl_cpu_start = s; bus.ctrl_global_halt = h; bus.next_addr = na;
      bus.ir_opcode = op; bus.cond_flag = c;
   endtask
   task automatic async_reset();
      #1 rst_n = 1'b0;
      #1 cmp_model();
      rst_n = 1'b1;
   endtask
   initial begin
      drive(0, 0, 2'd0, 8'h00, 0);
      #12;
      cmp_model();
      chk("reset_car", int'(bus.car), 0);
      chk("reset_count", int'(bus.ustep_count), 0);
      #1 rst_n = 1'b1;
      drive(1, 0, 2'd0, 8'h00, 0);
      tick();
      chk("start_car", int'(bus.car), 8'h00);
      chk("start_running", int'(bus.running), 1);
      repeat (3) tick();
      chk("inc_car", int'(bus.car), 8'h03);
      chk("inc_count", int'(bus.ustep_count), 3);
      async_reset();
      chk("arst_car", int'(bus.car), 0);
      chk("arst_running", int'(bus.running), 0);
      chk("arst_count", int'(bus.ustep_count), 0);
      tick();
      drive(1, 0, 2'd1, 8'h03, 0); tick();
      chk("map_op3", int'(bus.car), 8'h28);
      drive(1, 0, 2'd2, 8'h03, 0); tick();
      chk("goto_fetch", int'(bus.car), 8'h00);
      drive(1, 0, 2'd1, 8'h20, 0); tick();
      chk("illegal_car", int'(bus.car), 8'h00);
      chk("illegal_pulse", int'(bus.illegal_op), 1);
      drive(1, 0, 2'd0, 8'h20, 0); tick();
      chk("illegal_drop", int'(bus.illegal_op), 0);
      repeat (253) tick();
      chk("at_fe", int'(bus.car), 8'hFE);
      drive(1, 0, 2'd3, 8'h00, 1); tick();
      chk("skip_wrap", int'(bus.car), 8'h00);
      drive(1, 0, 2'd0, 8'h00, 0); repeat (5) tick();
      drive(1, 0, 2'd3, 8'h00, 1); tick();
      chk("skip_taken", int'(bus.car), 8'h07);
      drive(1, 0, 2'd2, 8'h00, 0); tick();
      drive(1, 0, 2'd0, 8'h00, 0); repeat (5) tick();
      drive(1, 0, 2'd3, 8'h00, 0); tick();
      chk("skip_not_taken", int'(bus.car), 8'h06);
      drive(1, 0, 2'd0, 8'h00, 0); repeat (249) tick();
      chk("at_ff", int'(bus.car), 8'hFF);
      tick();
      chk("inc_wrap", int'(bus.car), 8'h00);
      drive(1, 0, 2'd1, 8'h00, 0); tick();
      drive(1, 0, 2'd0, 8'h00, 0); repeat (2) tick();
      chk("at_12", int'(bus.car), 8'h12);
      drive(1, 1, 2'd0, 8'h00, 0); tick();
      chk("halt_flag", int'(bus.halted), 1);
      for (int i = 0; i < 10; i++) begin
         drive(1, 1'($urandom), 2'(i), 8'($urandom_range(0, 40)), 1'($urandom));
         tick();
      end
      chk("halt_hold_car", int'(bus.car), 8'h12);
      drive(0, 0, 2'd0, 8'h00, 0); tick();
      chk("halt_exit_car", int'(bus.car), 0);
      chk("halt_exit_halted", int'(bus.halted), 0);
      drive(1, 0, 2'd0, 8'h00, 0); tick();
      chk("restart_running", int'(bus.running), 1);
      tick();
      drive(0, 1, 2'd0, 8'h00, 0); tick();
      chk("stop_beats_halt_run", int'(bus.running), 0);
      chk("stop_beats_halt_hlt", int'(bus.halted), 0);
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, 2'($urandom),
               8'($urandom_range(0, 40)), 1'($urandom));
         tick();
         if ($urandom_range(0, 499) == 0) async_reset();
      end
      async_reset();
      drive(1, 0, 2'd0, 8'h00, 0);
      repeat (70000) tick();
      chk("saturate", int'(bus.ustep_count), 16'hFFFF);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
